// File: rtl/graphite_fifo_pkg.sv
// Shared FIFO definitions: buffering mode and the occupancy-counter width helper.
// The dual-clock FIFO successor reuses the same helper.
package graphite_fifo_pkg;

   typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

   // The count must reach DEPTH itself, so it needs one bit more than a pointer.
   function automatic int cnt_width(input int addr_len);
      return addr_len + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM on a single clock: one write port and one registered read port
// with a read enable. The read register holds its value while re_i is low.
module sync_fifo_ram #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact count, almost flags, sticky error flags and an optional
// first-word-fall-through output stage. In FWFT mode the RAM read register is the output stage.
module sync_fifo
   import graphite_fifo_pkg::*;
#(
   parameter int         ADDR_LEN        = 10,
   parameter int         DATA_WIDTH      = 32,
   parameter fifo_mode_e MODE            = FIFO_STD,
   parameter int         ALM_EMPTY_LEVEL = 1,
   parameter int         ALM_FULL_LEVEL  = (1 << ADDR_LEN) - 1
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic [DATA_WIDTH-1:0] d_i,
   input  logic                  enq_i,
   output logic                  full_o,
   output logic                  alm_full_o,
   output logic [DATA_WIDTH-1:0] q_o,
   input  logic                  deq_i,
   output logic                  empty_o,
   output logic                  alm_empty_o,
   output logic [ADDR_LEN:0]     count_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam int            CW     = cnt_width(ADDR_LEN);
   localparam logic [CW-1:0] DEPTH  = CW'(1 << ADDR_LEN);
   localparam logic [CW-1:0] AE_LVL = CW'(ALM_EMPTY_LEVEL);
   localparam logic [CW-1:0] AF_LVL = CW'(ALM_FULL_LEVEL);

   logic [ADDR_LEN-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]         cnt_q, cnt_d, ram_cnt;
   logic                  full_q, full_d, empty_q, empty_d;
   logic                  ae_q, ae_d, af_q, af_d;
   logic                  ovf_q, ovf_d, unf_q, unf_d;
   logic                  ov_q, ov_d;
   logic                  wr_acc, rd_acc, ram_re;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Acceptance uses the registered flags only, so a deq never frees a slot for a same-cycle enq.
   assign wr_acc  = enq_i && !full_q;
   assign rd_acc  = deq_i && !empty_q;
   assign ram_cnt = cnt_q - CW'(ov_q);

   always_comb begin
      ram_re = rd_acc;
      ov_d   = 1'b0;
      if (MODE == FIFO_FWFT) begin
         ram_re = (!ov_q || rd_acc) && (ram_cnt != '0);
         ov_d   = ram_re ? 1'b1 : (rd_acc ? 1'b0 : ov_q);
      end
   end

   always_comb begin
      wptr_d = wptr_q + ADDR_LEN'(wr_acc);
      rptr_d = rptr_q + ADDR_LEN'(ram_re);
      cnt_d  = cnt_q;
      case ({wr_acc, rd_acc})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      full_d  = (cnt_d == DEPTH);
      empty_d = (MODE == FIFO_FWFT) ? !ov_d : (cnt_d == '0);
      ae_d    = (cnt_d <= AE_LVL);
      af_d    = (cnt_d >= AF_LVL);
      ovf_d   = ovf_q || (enq_i && full_q);
      unf_d   = unf_q || (deq_i && empty_q);
   end

   // Flush behaves exactly like reset; RAM contents are left alone.
   always_ff @(posedge clk) begin
      if (rst_i || clear_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ae_q    <= 1'b1;
         af_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         ae_q    <= ae_d;
         af_q    <= af_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         ov_q    <= ov_d;
      end
   end

   sync_fifo_ram #(
      .AW (ADDR_LEN),
      .DW (DATA_WIDTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_acc),
      .waddr_i (wptr_q),
      .wdata_i (d_i),
      .re_i    (ram_re),
      .raddr_i (rptr_q),
      .rdata_o (ram_rdata)
   );

   assign q_o         = (MODE == FIFO_FWFT && !ov_q) ? '0 : ram_rdata;
   assign full_o      = full_q;
   assign empty_o     = empty_q;
   assign alm_full_o  = af_q;
   assign alm_empty_o = ae_q;
   assign count_o     = cnt_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a standard-mode and an FWFT instance share one stimulus stream;
// queue-based reference models predict every output after each clock edge.
module tb_sync_fifo;
   import graphite_fifo_pkg::*;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0, clear_i = 1'b0, enq_i = 1'b0, deq_i = 1'b0;
   logic [31:0] d_i = '0;

   logic [31:0] s_q, f_q;
   logic [3:0]  s_cnt, f_cnt;
   logic        s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;
   logic        f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sync_fifo #(.ADDR_LEN(3), .DATA_WIDTH(32), .MODE(FIFO_STD),
               .ALM_EMPTY_LEVEL(2), .ALM_FULL_LEVEL(6)) u_std (
      .clk(clk), .rst_i(rst_i), .clear_i(clear_i), .d_i(d_i), .enq_i(enq_i),
      .full_o(s_full), .alm_full_o(s_afull), .q_o(s_q), .deq_i(deq_i),
      .empty_o(s_empty), .alm_empty_o(s_aempty), .count_o(s_cnt),
      .overflow_o(s_ovf), .underflow_o(s_unf));

   sync_fifo #(.ADDR_LEN(3), .DATA_WIDTH(32), .MODE(FIFO_FWFT),
               .ALM_EMPTY_LEVEL(2), .ALM_FULL_LEVEL(6)) u_fw (
      .clk(clk), .rst_i(rst_i), .clear_i(clear_i), .d_i(d_i), .enq_i(enq_i),
      .full_o(f_full), .alm_full_o(f_afull), .q_o(f_q), .deq_i(deq_i),
      .empty_o(f_empty), .alm_empty_o(f_aempty), .count_o(f_cnt),
      .overflow_o(f_ovf), .underflow_o(f_unf));

   // Standard model: stored words, last word read out, sticky flags.
   logic [31:0] sq[$];
   logic [31:0] m_sq;
   bit          m_sqk, m_sov, m_sun;
   // FWFT model: words behind the head, plus the visible head word.
   logic [31:0] fq[$];
   logic [31:0] m_fhd;
   bit          m_fhv, m_fov, m_fun;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int sn, fn;
      sn = sq.size();
      fn = fq.size() + int'(m_fhv);
      chk("std_count",  32'(s_cnt),    32'(sn));
      chk("std_empty",  32'(s_empty),  32'(sn == 0));
      chk("std_full",   32'(s_full),   32'(sn == 8));
      chk("std_aempty", 32'(s_aempty), 32'(sn <= 2));
      chk("std_afull",  32'(s_afull),  32'(sn >= 6));
      chk("std_ovf",    32'(s_ovf),    32'(m_sov));
      chk("std_unf",    32'(s_unf),    32'(m_sun));
      if (m_sqk) chk("std_q", s_q, m_sq);
      chk("fw_count",  32'(f_cnt),    32'(fn));
      chk("fw_empty",  32'(f_empty),  32'(!m_fhv));
      chk("fw_full",   32'(f_full),   32'(fn == 8));
      chk("fw_aempty", 32'(f_aempty), 32'(fn <= 2));
      chk("fw_afull",  32'(f_afull),  32'(fn >= 6));
      chk("fw_ovf",    32'(f_ovf),    32'(m_fov));
      chk("fw_unf",    32'(f_unf),    32'(m_fun));
      chk("fw_q",      f_q,           m_fhv ? m_fhd : 32'h0);
   endtask

   task automatic step(input bit r, input bit c, input bit e, input bit dq, input logic [31:0] d);
      bit sfull, sempty, ffull, fempty, frd;
      rst_i = r; clear_i = c; enq_i = e; deq_i = dq; d_i = d;
      sfull  = (sq.size() == 8);
      sempty = (sq.size() == 0);
      ffull  = (fq.size() + int'(m_fhv) == 8);
      fempty = !m_fhv;
      @(posedge clk);
      #1;
      if (r || c) begin
         sq.delete(); m_sov = 0; m_sun = 0; m_sqk = 0;
         fq.delete(); m_fhv = 0; m_fov = 0; m_fun = 0;
      end else begin
         if (e && sfull)  m_sov = 1;
         if (dq && sempty) m_sun = 1;
         if (dq && !sempty) begin m_sq = sq.pop_front(); m_sqk = 1; end
         if (e && !sfull) sq.push_back(d);
         frd = dq && !fempty;
         if (e && ffull)  m_fov = 1;
         if (dq && fempty) m_fun = 1;
         // Head refills from stored words when empty or being consumed.
         if ((!m_fhv || frd) && fq.size() > 0) begin m_fhd = fq.pop_front(); m_fhv = 1; end
         else if (frd) m_fhv = 0;
         if (e && !ffull) fq.push_back(d);
      end
      check_all();
   endtask

   initial begin
      logic [31:0] w;
      step(1, 0, 0, 0, 0);
      step(1, 0, 1, 1, 32'h55);
      chk("rst_std_empty", 32'(s_empty), 32'h1);
      chk("rst_fw_q", f_q, 32'h0);

      // Fill to full, then one rejected enq.
      for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 32'h10 + 32'(i));
      chk("fill_full", 32'(s_full), 32'h1);
      chk("fill_count", 32'(s_cnt), 32'h8);
      step(0, 0, 1, 0, 32'h99);
      chk("fill_ovf", 32'(s_ovf), 32'h1);

      // Drain in order, then one rejected deq.
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 1, 0);
         chk("drain_q", s_q, 32'h10 + 32'(i));
      end
      chk("drain_empty", 32'(s_empty), 32'h1);
      step(0, 0, 0, 1, 0);
      chk("drain_unf", 32'(s_unf), 32'h1);

      // Steady three-word occupancy with simultaneous traffic across the pointer wrap.
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'h100 + 32'(i));
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 1, 1, $urandom);
         chk("wrap_count", 32'(s_cnt), 32'h3);
      end

      // FWFT write-to-visible latency.
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 32'hABCD);
      chk("fwft_lat_t0_empty", 32'(f_empty), 32'h1);
      step(0, 0, 0, 0, 0);
      chk("fwft_lat_t1_empty", 32'(f_empty), 32'h0);
      chk("fwft_lat_t1_q", f_q, 32'hABCD);

      // FWFT back-to-back drain of four words.
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 32'h200 + 32'(i));
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         chk("fwft_b2b_q", f_q, 32'h200 + 32'(i));
         step(0, 0, 0, 1, 0);
      end

      // Threshold sweep 0 -> 8 -> 0.
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 0, $urandom);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);

      // Clear with enq and deq pending at count 5 and overflow set.
      for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 32'h300 + 32'(i));
      step(0, 0, 1, 0, 32'h3FF);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
      chk("clr_pre_count", 32'(s_cnt), 32'h5);
      step(0, 1, 1, 1, 32'hDEAD);
      chk("clr_count", 32'(s_cnt), 32'h0);
      chk("clr_empty", 32'(s_empty), 32'h1);
      chk("clr_ovf", 32'(s_ovf), 32'h0);
      step(0, 0, 1, 0, 32'h5A5A);
      step(0, 0, 0, 0, 0);
      chk("clr_fw_q", f_q, 32'h5A5A);
      step(0, 0, 0, 1, 0);
      chk("clr_std_q", s_q, 32'h5A5A);

      // Random traffic with occasional flushes and resets.
      for (int i = 0; i < 600; i++) begin
         int bias;
         bias = (i < 200) ? 70 : (i < 400) ? 30 : 50;
         w = $urandom;
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 79) == 0),
              ($urandom_range(0, 99) < bias), ($urandom_range(0, 99) < 100 - bias), w);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO for same-domain buffering: command queues, rasteriser-to-framebuffer staging, UART byte buffers. Successor to the dual-clock FIFO for cases where both sides share one clock. Adds:
- full 2^ADDR_LEN capacity,
- exact occupancy count,
- programmable almost-empty/almost-full levels,
- first-word-fall-through (FWFT) mode,
- synchronous flush,
- sticky overflow/underflow error flags.

## Interface
- ADDR_LEN, 10, log2 of depth; DEPTH = 2^ADDR_LEN words
- DATA_WIDTH, 32, word width
- MODE, FIFO_STD, fifo_mode_e: FIFO_STD (registered read on deq) or FIFO_FWFT (head word presented without deq)
- ALM_EMPTY_LEVEL, 1, alm_empty_o asserted when count <= this (0..DEPTH-1)
- ALM_FULL_LEVEL, DEPTH-1, alm_full_o asserted when count >= this (1..DEPTH)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_i  in  1  reset; one clock, reset is synchronous and active-high
- clear_i  in  1  synchronous flush, same effect as rst_i on all state
- d_i  in  DATA_WIDTH  write data
- enq_i  in  1  enqueue request
- full_o  out  1  no space; enq_i ignored
- alm_full_o  out  1  count >= ALM_FULL_LEVEL
- q_o  out  DATA_WIDTH  read data
- deq_i  in  1  dequeue request
- empty_o  out  1  no readable word; deq_i ignored
- alm_empty_o  out  1  count <= ALM_EMPTY_LEVEL
- count_o  out  ADDR_LEN+1  words held (0..DEPTH)
- overflow_o  out  1  sticky: enq_i while full_o
- underflow_o  out  1  sticky: deq_i while empty_o

## Operation

Acceptance and pointers:
- Write accepted iff enq_i && !full_o. Read accepted iff deq_i && !empty_o.
- Flags are registered, so full_o/empty_o sampled in the current cycle decide acceptance. A deq in the same cycle does NOT free a slot for an enq while full.
- Pointers are ADDR_LEN bits and wrap naturally at DEPTH-1 -> 0. count_o is ADDR_LEN+1 bits and is the sole source of full/empty; the FIFO holds exactly DEPTH words.
- Both accepted in the same cycle: count unchanged, both pointers advance.

Flag updates:
- count, full_o, empty_o, alm_* are all updated from next-count at the same edge.
- full_o = (count == DEPTH).
- empty_o in FIFO_STD = (count == 0).
- empty_o in FIFO_FWFT = !output-register-valid.

Mode behaviour:
- FIFO_FWFT: count includes the word in the output register. The output stage refills from RAM whenever it is empty or being dequeued and RAM holds data.

Error flags:
- overflow_o / underflow_o set on the rejected request and hold until rst_i or clear_i.

Priority:
- rst_i > clear_i > enq/deq.
- A clear in a cycle with enq/deq discards both requests; the FIFO is empty the next cycle.

Reset values (rst_i or clear_i):
- empty_o=1, alm_empty_o=1, full_o=0, alm_full_o=0, count_o=0, overflow_o=0, underflow_o=0.
- q_o=0 in FIFO_FWFT; in FIFO_STD, q_o is don't-care until the first accepted read.
- RAM contents are not cleared.

## Timing
- Write accepted at edge t into an empty FIFO:
  - count_o=1 after edge t.
  - FIFO_STD: empty_o falls after edge t.
  - FIFO_FWFT: empty_o falls and q_o shows the word after edge t+1 (2-cycle write-to-visible).
- FIFO_STD read accepted at edge r: q_o valid after edge r and held until the next accepted read.
- FIFO_FWFT: q_o is valid whenever empty_o=0. Read accepted at edge r: the next word appears after edge r with no bubble when RAM is non-empty.
- Throughput is one write and one read per cycle sustained in both modes.
- Last word read while a write lands in the same cycle:
  - FIFO_STD: empty_o stays 0.
  - FIFO_FWFT: empty_o may assert for at most one cycle (refill bubble).

## Structure
- Shared package graphite_fifo_pkg holds:
  - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT},
  - count-width helper constant/function, for reuse by the dual-clock FIFO successor.
- One sub-module: sync_fifo_ram, a single-clock simple dual-port RAM (one write port, one registered read port with read-enable), inferable as BRAM.
- Control (pointers, count, flags, FWFT output stage) stays in sync_fifo.

## Test plan
- Reset and basic fill (ADDR_LEN=3, DEPTH=8):
  - After reset, check empty_o=1, count_o=0.
  - 8 writes 0x10..0x17 -> full_o=1 after the 8th edge, count_o=8.
  - 9th enq -> data rejected, overflow_o=1 sticky.
- Drain:
  - From full, 8 reads in FIFO_STD -> q_o sequence 0x10..0x17, each valid the cycle after its deq.
  - empty_o=1 after the 8th read.
  - Extra deq -> underflow_o=1.
- Wrap-around and simultaneous operation:
  - With 3 words held, 20 cycles of simultaneous enq/deq -> count_o constant 3, data in order across the pointer wrap, flags unchanged.
- FWFT mode:
  - Single write of 0xABCD into empty -> empty_o=0 and q_o=0xABCD exactly 2 cycles after the write edge.
  - Back-to-back deqs on a 4-word queue -> one word per cycle, no bubble.
- Thresholds:
  - ALM_EMPTY_LEVEL=2, ALM_FULL_LEVEL=6: step count 0->8->0.
  - alm_empty_o=1 exactly for count<=2; alm_full_o=1 exactly for count>=6.
- Clear:
  - clear_i asserted with enq_i and deq_i at count=5 and overflow_o set -> next cycle count_o=0, empty_o=1, overflow_o=0.
  - The enq is discarded; a subsequent write/read returns the new word.
